// File: rtl/wl_pkg.sv
// Shared types and size helpers for the weight-tile load controller.
package wl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DATA,
        S_DONE
    } wl_state_e;

    localparam logic [31:0] DEF_LAYER_STRIDE = 32'h0001_0000;
    localparam logic [31:0] DEF_HEAD_STRIDE  = 32'h0000_2000;

    function automatic int tile_bytes(input int beats, input int data_w);
        return beats * data_w / 8;
    endfunction

    function automatic int burst_bytes(input int max_burst, input int data_w);
        return max_burst * data_w / 8;
    endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Fetches one weight tile as fixed-length read bursts and streams the beats
// into the tile buffer; one command at a time, one burst outstanding.
module weight_load_ctrl
    import wl_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 64,
    parameter int                TILE_BEATS   = 64,
    parameter int                MAX_BURST    = 16,
    parameter int                NUM_SEL      = 4,
    parameter logic [ADDR_W-1:0] LAYER_STRIDE = ADDR_W'(DEF_LAYER_STRIDE),
    parameter logic [ADDR_W-1:0] HEAD_STRIDE  = ADDR_W'(DEF_HEAD_STRIDE)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_SEL*ADDR_W-1:0]     base_addr,
    input  logic                          wl_start,
    input  logic                          wl_start_ap_vld,
    input  logic [31:0]                   wl_addr_sel,
    input  logic [31:0]                   wl_layer,
    input  logic [31:0]                   wl_head,
    input  logic [31:0]                   wl_tile,
    output logic                          wl_ready,
    output logic                          dma_done,
    output logic                          wl_err,
    output logic                          rd_req_valid,
    input  logic                          rd_req_ready,
    output logic [ADDR_W-1:0]             rd_req_addr,
    output logic [7:0]                    rd_req_len,
    input  logic                          rd_data_valid,
    output logic                          rd_data_ready,
    input  logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_data_last,
    output logic                          buf_we,
    output logic [$clog2(TILE_BEATS)-1:0] buf_addr,
    output logic [DATA_W-1:0]             buf_wdata
);

    localparam int BA_W        = $clog2(TILE_BEATS);
    localparam int NUM_BURSTS  = TILE_BEATS / MAX_BURST;
    localparam int BC_W        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BIB_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SEL_W       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int TILE_BYTES  = tile_bytes(TILE_BEATS, DATA_W);
    localparam int BURST_BYTES = burst_bytes(MAX_BURST, DATA_W);

    wl_state_e         r_state, w_next;
    logic [31:0]       r_sel, r_layer, r_head, r_tile;
    logic [ADDR_W-1:0] r_tile_addr;
    logic [BC_W-1:0]   r_burst_cnt;
    logic [BA_W-1:0]   r_beat_cnt;
    logic [BIB_W-1:0]  r_bib;
    logic              r_err;

    logic              w_accept, w_sel_ok, w_beat, w_burst_end, w_last_burst;
    logic [ADDR_W-1:0] w_base, w_tile_addr;

    assign w_accept     = (r_state == S_IDLE) && wl_start && wl_start_ap_vld;
    assign w_sel_ok     = r_sel < 32'(NUM_SEL);
    assign w_base       = base_addr[r_sel[SEL_W-1:0]*ADDR_W +: ADDR_W];
    // Every term is reduced to ADDR_W bits, so overflow wraps silently.
    assign w_tile_addr  = w_base
                        + ADDR_W'(r_layer) * LAYER_STRIDE
                        + ADDR_W'(r_head)  * HEAD_STRIDE
                        + ADDR_W'(r_tile)  * ADDR_W'(TILE_BYTES);
    assign w_beat       = (r_state == S_DATA) && rd_data_valid;
    assign w_burst_end  = w_beat && (r_bib == BIB_W'(MAX_BURST - 1));
    assign w_last_burst = r_burst_cnt == BC_W'(NUM_BURSTS - 1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        wl_ready      = 1'b0;
        rd_req_valid  = 1'b0;
        rd_data_ready = 1'b0;
        dma_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                wl_ready = 1'b1;
                if (w_accept) w_next = S_CALC;
            end
            S_CALC: w_next = w_sel_ok ? S_REQ : S_DONE;
            S_REQ: begin
                rd_req_valid = 1'b1;
                if (rd_req_ready) w_next = S_DATA;
            end
            S_DATA: begin
                rd_data_ready = 1'b1;
                if (w_burst_end) w_next = w_last_burst ? S_DONE : S_REQ;
            end
            S_DONE: begin
                dma_done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sel       <= '0;
            r_layer     <= '0;
            r_head      <= '0;
            r_tile      <= '0;
            r_tile_addr <= '0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_bib       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel   <= wl_addr_sel;
                r_layer <= wl_layer;
                r_head  <= wl_head;
                r_tile  <= wl_tile;
                r_err   <= 1'b0;
            end
            if (r_state == S_CALC) begin
                if (!w_sel_ok) begin
                    r_err <= 1'b1;
                end else begin
                    r_tile_addr <= w_tile_addr;
                    r_burst_cnt <= '0;
                    r_beat_cnt  <= '0;
                    r_bib       <= '0;
                end
            end
            // Burst boundaries follow the beat count; a misplaced last only flags.
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_burst_end) begin
                    r_bib <= '0;
                    if (!rd_data_last) r_err <= 1'b1;
                    if (!w_last_burst) r_burst_cnt <= r_burst_cnt + 1'b1;
                end else begin
                    r_bib <= r_bib + 1'b1;
                    if (rd_data_last) r_err <= 1'b1;
                end
            end
        end
    end

    assign rd_req_addr = (r_state == S_REQ)
                       ? r_tile_addr + ADDR_W'(r_burst_cnt) * ADDR_W'(BURST_BYTES) : '0;
    assign rd_req_len  = (r_state == S_REQ) ? 8'(MAX_BURST - 1) : 8'd0;
    assign buf_we      = w_beat;
    assign buf_addr    = w_beat ? r_beat_cnt : '0;
    assign buf_wdata   = w_beat ? rd_data : '0;
    assign wl_err      = r_err;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench: stimulus queues expected requests/writes/completions,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_weight_load_ctrl;

    localparam int ADDR_W = 32, DATA_W = 64, TILE_BEATS = 64, MAX_BURST = 16, NUM_SEL = 4;
    localparam int BA_W = 6;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst_n = 1'b0;
    logic [NUM_SEL*ADDR_W-1:0] base_addr;
    logic                      wl_start, wl_start_ap_vld;
    logic [31:0]               wl_addr_sel, wl_layer, wl_head, wl_tile;
    logic                      wl_ready, dma_done, wl_err;
    logic                      rd_req_valid, rd_req_ready;
    logic [ADDR_W-1:0]         rd_req_addr;
    logic [7:0]                rd_req_len;
    logic                      rd_data_valid, rd_data_ready, rd_data_last;
    logic [DATA_W-1:0]         rd_data;
    logic                      buf_we;
    logic [BA_W-1:0]           buf_addr;
    logic [DATA_W-1:0]         buf_wdata;

    typedef struct packed {
        logic [BA_W-1:0]   a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic [ADDR_W-1:0] exp_req_q[$];
    wr_t               exp_wr_q[$];
    logic              exp_done_q[$];
    int                checks = 0, errors = 0;

    weight_load_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TILE_BEATS(TILE_BEATS),
        .MAX_BURST(MAX_BURST), .NUM_SEL(NUM_SEL)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .base_addr(base_addr),
        .wl_start(wl_start), .wl_start_ap_vld(wl_start_ap_vld),
        .wl_addr_sel(wl_addr_sel), .wl_layer(wl_layer), .wl_head(wl_head), .wl_tile(wl_tile),
        .wl_ready(wl_ready), .dma_done(dma_done), .wl_err(wl_err),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor
    logic              prev_pend = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    wr_t               mw;
    logic [ADDR_W-1:0] ma;
    logic              me;

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (rd_req_valid && prev_pend) chk("req_addr_stable", rd_req_addr, prev_addr);
            if (rd_req_valid && rd_req_ready) begin
                if (exp_req_q.size() == 0) fail("unexpected_req", rd_req_addr);
                else begin
                    ma = exp_req_q.pop_front();
                    chk("req_addr", rd_req_addr, ma);
                    chk("req_len", rd_req_len, 8'd15);
                end
            end
            if (buf_we) begin
                if (exp_wr_q.size() == 0) fail("unexpected_buf_we", buf_addr);
                else begin
                    mw = exp_wr_q.pop_front();
                    chk("buf_addr", buf_addr, mw.a);
                    chk("buf_wdata", buf_wdata, mw.d);
                end
            end
            if (dma_done) begin
                if (exp_done_q.size() == 0) fail("unexpected_dma_done", wl_err);
                else begin
                    me = exp_done_q.pop_front();
                    chk("done_err", wl_err, me);
                end
            end
        end
        prev_pend <= ap_rst_n && rd_req_valid && !rd_req_ready;
        prev_addr <= rd_req_addr;
    end

    task automatic run_load(input logic [31:0] sel, layer, head, tile,
                            input logic [31:0] exp_addr, input logic exp_err,
                            input int req_wait, input bit gaps, input bit bad_last,
                            input bit poke, input int rst_burst, input logic [31:0] tag);
        int wc;
        int k;
        if (sel < NUM_SEL) begin
            for (int b = 0; b < 4; b++) exp_req_q.push_back(exp_addr + 32'(b * 128));
            for (int i = 0; i < 64; i++) exp_wr_q.push_back('{a: 6'(i), d: {tag, 32'(i)}});
        end
        exp_done_q.push_back(exp_err);

        wc = 0;
        while (!wl_ready && wc < 50) begin tick; wc++; end
        wl_start = 1'b1; wl_start_ap_vld = 1'b1;
        wl_addr_sel = sel; wl_layer = layer; wl_head = head; wl_tile = tile;
        tick;
        wl_start = 1'b0; wl_start_ap_vld = 1'b0;
        wl_addr_sel = 32'hDEAD_BEEF; wl_layer = 32'h1234_5678;
        chk("err_clear_on_accept", wl_err, 1'b0);
        chk("calc_no_req", rd_req_valid, 1'b0);

        if (sel >= NUM_SEL) begin
            tick;
            chk("bad_sel_done", dma_done, 1'b1);
            chk("bad_sel_err", wl_err, 1'b1);
            tick;
            chk("bad_sel_ready", wl_ready, 1'b1);
            return;
        end

        k = 0;
        for (int b = 0; b < 4; b++) begin
            wc = 0;
            while (!rd_req_valid && wc < 50) begin tick; wc++; end
            if (!rd_req_valid) begin
                fail("req_timeout", wc);
                return;
            end
            if (b == 0) chk("first_req_latency", wc, 1);
            for (int i = 0; i < req_wait; i++) tick;
            rd_req_ready = 1'b1;
            tick;
            rd_req_ready = 1'b0;
            for (int j = 0; j < 16; j++) begin
                if (gaps && (j % 2 == 1)) begin
                    rd_data_valid = 1'b0;
                    tick;
                end
                if (rst_burst == b && j == 6) begin
                    rd_data_valid = 1'b0;
                    ap_rst_n = 1'b0;
                    #1;
                    chk("rst_wl_ready", wl_ready, 1'b1);
                    chk("rst_req_valid", rd_req_valid, 1'b0);
                    chk("rst_data_ready", rd_data_ready, 1'b0);
                    chk("rst_buf_we", buf_we, 1'b0);
                    chk("rst_dma_done", dma_done, 1'b0);
                    chk("rst_req_addr", rd_req_addr, 32'h0);
                    exp_req_q.delete();
                    exp_wr_q.delete();
                    exp_done_q.delete();
                    repeat (3) tick;
                    ap_rst_n = 1'b1;
                    tick;
                    return;
                end
                rd_data_valid = 1'b1;
                rd_data       = {tag, 32'(k)};
                rd_data_last  = bad_last ? ((k == 4) || (j == 15 && k != 15)) : (j == 15);
                if (poke && k == 3) begin
                    wl_start = 1'b1; wl_start_ap_vld = 1'b1;
                    wl_addr_sel = 32'd0; wl_layer = 32'd5; wl_head = 32'd1; wl_tile = 32'd1;
                end
                tick;
                wl_start = 1'b0; wl_start_ap_vld = 1'b0;
                k++;
            end
            rd_data_valid = 1'b0;
            rd_data_last  = 1'b0;
        end
        chk("done_after_last_beat", dma_done, 1'b1);
        chk("not_ready_in_done", wl_ready, 1'b0);
        tick;
        chk("ready_after_done", wl_ready, 1'b1);
        chk("final_err", wl_err, exp_err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        base_addr = {32'hFFFF_F000, 32'h0000_0000, 32'h8000_0000, 32'h1000_0000};
        wl_start = 1'b0; wl_start_ap_vld = 1'b0;
        wl_addr_sel = '0; wl_layer = '0; wl_head = '0; wl_tile = '0;
        rd_req_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0; rd_data_last = 1'b0;
        #1;
        chk("reset_wl_ready", wl_ready, 1'b1);
        chk("reset_dma_done", dma_done, 1'b0);
        chk("reset_wl_err", wl_err, 1'b0);
        chk("reset_req_valid", rd_req_valid, 1'b0);
        chk("reset_data_ready", rd_data_ready, 1'b0);
        chk("reset_buf_we", buf_we, 1'b0);
        repeat (3) tick;
        ap_rst_n = 1'b1;
        tick;

        // nominal
        run_load(1, 1, 2, 3, 32'h8001_4600, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 32'h1111_0000);
        // backpressure on both channels
        run_load(1, 1, 2, 3, 32'h8001_4600, 1'b0, 5, 1'b1, 1'b0, 1'b0, -1, 32'h2222_0000);
        // out-of-range region select
        run_load(7, 0, 0, 0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        // next good command clears the error
        run_load(0, 32'h10, 0, 0, 32'h1010_0000, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1, 32'h3333_0000);
        // start pulsed mid-load is ignored
        run_load(1, 1, 2, 3, 32'h8001_4600, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1, 32'h4444_0000);
        // missing/early last flags
        run_load(1, 1, 2, 3, 32'h8001_4600, 1'b1, 0, 1'b0, 1'b1, 1'b0, -1, 32'h5555_0000);
        // reset during the second burst
        run_load(1, 1, 2, 3, 32'h8001_4600, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 32'h6666_0000);
        // fresh command after reset, address wraps modulo 2^32
        run_load(3, 32'h0000_FFFF, 1, 2, 32'hFFFF_1400, 1'b0, 2, 1'b1, 1'b0, 1'b0, -1, 32'h7777_0000);

        repeat (5) tick;
        chk("req_q_drained", exp_req_q.size(), 0);
        chk("wr_q_drained", exp_wr_q.size(), 0);
        chk("done_q_drained", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Weight-load controller sitting directly upstream of `run_head_group`'s `wl_*` handshake. It accepts one tile-load command (`wl_start` with `addr_sel`/`layer`/`head`/`tile`) and computes the tile's external byte address. It fetches the tile as a sequence of fixed-length read bursts, writes every returned beat into the on-chip weight tile buffer, and reports completion through `wl_ready`/`dma_done`.

## Interface
- `ADDR_W`, 32, external byte-address width
- `DATA_W`, 64, read-data/buffer word width
- `TILE_BEATS`, 64, beats per tile (multiple of `MAX_BURST`)
- `MAX_BURST`, 16, beats per read burst
- `NUM_SEL`, 4, number of weight base-address regions
- `LAYER_STRIDE`, 32'h0001_0000, bytes per layer
- `HEAD_STRIDE`, 32'h0000_2000, bytes per head
- `ap_clk` in 1: clock; all logic on rising edge
- `ap_rst_n` in 1: asynchronous active-low reset
- `base_addr` in `NUM_SEL*ADDR_W`: region base addresses; region k = bits [k*ADDR_W +: ADDR_W]; static during a load
- `wl_start`, `wl_start_ap_vld` in 1 each: command strobe; accepted only when both high and `wl_ready`=1
- `wl_addr_sel`, `wl_layer`, `wl_head`, `wl_tile` in 32 each: command fields, sampled on accept
- `wl_ready` out 1: high only in IDLE
- `dma_done` out 1: one-cycle completion pulse
- `wl_err` out 1: sticky error flag; cleared on next accepted command
- `rd_req_valid` out 1, `rd_req_ready` in 1, `rd_req_addr` out `ADDR_W`, `rd_req_len` out 8 (beats-1): burst request channel
- `rd_data_valid` in 1, `rd_data_ready` out 1, `rd_data` in `DATA_W`, `rd_data_last` in 1: read data channel
- `buf_we` out 1, `buf_addr` out `$clog2(TILE_BEATS)`, `buf_wdata` out `DATA_W`: tile-buffer write port

## Operation
- TILE_BYTES = TILE_BEATS*DATA_W/8; BURST_BYTES = MAX_BURST*DATA_W/8; NUM_BURSTS = TILE_BEATS/MAX_BURST.
- States: IDLE, CALC, REQ, DATA, DONE.
- IDLE: `wl_ready`=1. On accept: latch fields, clear `wl_err`, go to CALC.
- CALC (1 cycle):
  - If `addr_sel` >= NUM_SEL: set `wl_err`, go to DONE; no requests are issued.
  - Otherwise: tile_addr = base[sel] + layer*LAYER_STRIDE + head*HEAD_STRIDE + tile*TILE_BYTES. Products and sum are truncated modulo 2^ADDR_W (wrap, no error). Set burst_cnt=0, beat_cnt=0, go to REQ.
- REQ:
  - `rd_req_valid`=1, `rd_req_addr` = tile_addr + burst_cnt*BURST_BYTES, `rd_req_len` = MAX_BURST-1.
  - Address and length are held stable until `rd_req_ready`. On handshake go to DATA.
- DATA:
  - `rd_data_ready`=1. Each beat with `rd_data_valid`: `buf_we`=1, `buf_addr`=beat_cnt, `buf_wdata`=`rd_data` (combinational, same cycle), then beat_cnt++.
  - On the beat that is the MAX_BURST-th of the burst:
    - If `rd_data_last`=0, set `wl_err`.
    - If this was the last burst (burst_cnt = NUM_BURSTS-1), go to DONE; otherwise burst_cnt++ and go to REQ.
  - `rd_data_last`=1 on any other beat sets `wl_err`, and counting continues by beat count.
- DONE (1 cycle): `dma_done`=1, then IDLE.
- `wl_start` while not in IDLE is ignored; no queueing.
- Exactly one burst is outstanding at a time.

## Timing
- Reset (async assert, sync release) forces IDLE. Reset values: `wl_ready`=1, all other outputs 0, counters 0.
- Reset mid-load aborts the load with no `dma_done`. A partial buffer write is acceptable.
- Accept at edge N:
  - CALC during N+1.
  - `rd_req_valid` high from N+2.
- Last beat accepted at edge M: `dma_done` high during cycle M+1, `wl_ready` high from M+2.
- Zero-stall tile latency: 2 + NUM_BURSTS*(1 + request wait + MAX_BURST + data gap) + 1 cycles.
- Bad `addr_sel`: `dma_done` and `wl_err` both high 2 cycles after accept.
- `rd_req_ready` low: request held indefinitely. `rd_data_valid` gaps: simply stall.

## Structure
- Package `wl_pkg`: state enum `wl_state_e`, default stride constants, TILE_BYTES/BURST_BYTES derivation functions.
- Single flat module. The address computation may be a small function in `wl_pkg`; no sub-modules.

## Test plan
- Nominal load: base[1]=32'h8000_0000, sel=1, layer=1, head=2, tile=3.
  - 4 requests at 8001_4600, 8001_4680, 8001_4700, 8001_4780, all len=15.
  - 64 `buf_we` at addresses 0..63 with matching data.
  - One `dma_done`, `wl_err`=0.
- Backpressure: `rd_req_ready` low 5 cycles per burst, `rd_data_valid` toggling 50%.
  - Same buffer contents.
  - Address held stable while unacknowledged.
- sel=7: no `rd_req_valid`; `dma_done` and `wl_err`=1 at accept+2; next valid command clears `wl_err`.
- `wl_start` pulsed mid-load with different fields: ignored; addresses follow the first command only.
- `rd_data_last` missing on beat 16 and asserted early on beat 5: `wl_err`=1 after load; `dma_done` still after 64 beats.
- `ap_rst_n` low during burst 2: outputs return to reset values immediately, no `dma_done`; a following fresh command completes normally.
